// File: rtl/cache_pkg.sv
// Shared types, widths and address field helpers for the direct-mapped cache.
package cache_pkg;

    localparam int ADDR_W    = 15;
    localparam int INDEX_W   = 8;
    localparam int OFFSET_W  = 2;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int MISS_WAIT = 2;
    localparam int LINE_W    = 128;

    typedef enum logic {
        COMPARE = 1'b0,
        FILL    = 1'b1
    } state_t;

    function automatic logic [TAG_W-1:0] tagOf(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] indexOf(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] offsetOf(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: async-reset valid bits plus unreset tag and 128-bit data arrays.
module cache_line_array
    import cache_pkg::*;
(
    input  logic                clock,
    input  logic                resetN,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_data,
    input  logic                fill_en,
    input  logic                store_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [LINE_W-1:0]   wr_line,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_word
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // A fill replaces the whole line; a store hit patches only one word.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end else if (store_en) begin
            lines[wr_index][{wr_offset, 5'b00000} +: 32] <= wr_word;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate direct-mapped cache controller with hit statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W    = cache_pkg::ADDR_W,
    parameter int INDEX_W   = cache_pkg::INDEX_W,
    parameter int MISS_WAIT = cache_pkg::MISS_WAIT
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              cpuRead,
    input  logic              cpuWrite,
    input  logic [ADDR_W-1:0] cpuAddress,
    input  logic [31:0]       cpuDataIn,
    output logic [31:0]       cpuDataOut,
    output logic              cpuReady,
    output logic [ADDR_W-1:0] memAddress,
    input  logic [127:0]      memDataIn,
    output logic              memWrite,
    output logic [31:0]       memDataOut,
    output logic [15:0]       readCount,
    output logic [15:0]       readHitCount
);

    localparam int WAIT_W = $clog2(MISS_WAIT) + 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MISS_WAIT - 1);

    state_t              state, next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                miss_flag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_data;
    logic                hit;
    logic                fill_en;
    logic                store_en;
    logic                start_fill;
    logic                load_done;

    cache_line_array u_lines (
        .clock     (clock),
        .resetN    (resetN),
        .rd_index  (indexOf(cpuAddress)),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .fill_en   (fill_en),
        .store_en  (store_en),
        .wr_index  (indexOf(cpuAddress)),
        .wr_tag    (tagOf(cpuAddress)),
        .wr_line   (memDataIn),
        .wr_offset (offsetOf(cpuAddress)),
        .wr_word   (cpuDataIn)
    );

    assign hit        = rd_valid && (rd_tag == tagOf(cpuAddress));
    assign memDataOut = cpuDataIn;
    assign load_done  = cpuReady && cpuRead && !cpuWrite;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= COMPARE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cpuReady   = 1'b0;
        cpuDataOut = '0;
        memWrite   = 1'b0;
        memAddress = cpuAddress;
        fill_en    = 1'b0;
        store_en   = 1'b0;
        start_fill = 1'b0;
        case (state)
            COMPARE: begin
                if (cpuWrite) begin
                    memWrite = 1'b1;
                    cpuReady = 1'b1;
                    store_en = hit;
                end else if (cpuRead) begin
                    if (hit) begin
                        cpuReady   = 1'b1;
                        cpuDataOut = rd_data[{offsetOf(cpuAddress), 5'b00000} +: 32];
                    end else begin
                        start_fill = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                memAddress = {tagOf(cpuAddress), indexOf(cpuAddress), 2'b00};
                if (wait_cnt == LAST_WAIT) begin
                    fill_en    = 1'b1;
                    next_state = COMPARE;
                end
            end
            default: next_state = COMPARE;
        endcase
        // Keep the CPU and memory strobes quiet for the whole reset interval.
        if (!resetN) begin
            cpuReady   = 1'b0;
            cpuDataOut = '0;
            memWrite   = 1'b0;
            store_en   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wait_cnt     <= '0;
            miss_flag    <= 1'b0;
            readCount    <= '0;
            readHitCount <= '0;
        end else begin
            if (start_fill) begin
                wait_cnt <= '0;
            end else if (state == FILL) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (start_fill) begin
                miss_flag <= 1'b1;
            end else if (load_done) begin
                miss_flag <= 1'b0;
            end
            if (load_done) begin
                if (readCount != 16'hFFFF) readCount <= readCount + 16'd1;
                if (!miss_flag && readHitCount != 16'hFFFF) readHitCount <= readHitCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a latency-checking block memory model.
module tb_cache_controller;

    localparam int MISS_WAIT = 2;

    logic         clock;
    logic         resetN;
    logic         cpuRead;
    logic         cpuWrite;
    logic [14:0]  cpuAddress;
    logic [31:0]  cpuDataIn;
    logic [31:0]  cpuDataOut;
    logic         cpuReady;
    logic [14:0]  memAddress;
    logic [127:0] memDataIn;
    logic         memWrite;
    logic [31:0]  memDataOut;
    logic [15:0]  readCount;
    logic [15:0]  readHitCount;

    int checks   = 0;
    int failures = 0;

    cache_controller #(.ADDR_W(15), .INDEX_W(8), .MISS_WAIT(MISS_WAIT)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .cpuRead      (cpuRead),
        .cpuWrite     (cpuWrite),
        .cpuAddress   (cpuAddress),
        .cpuDataIn    (cpuDataIn),
        .cpuDataOut   (cpuDataOut),
        .cpuReady     (cpuReady),
        .memAddress   (memAddress),
        .memDataIn    (memDataIn),
        .memWrite     (memWrite),
        .memDataOut   (memDataOut),
        .readCount    (readCount),
        .readHitCount (readHitCount)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [31:0] mem [32768];
    int          stall_cnt;
    logic [14:0] blk;

    initial begin
        for (int n = 0; n < 32768; n++) mem[n] = 32'd0;
        for (int n = 184; n <= 200; n++) mem[n] = 32'(n + 100);
        stall_cnt = 0;
    end

    // Counts consecutive stalled load cycles; the block is only presented once
    // the request has been stalled for the full miss latency.
    always @(negedge clock) begin
        if (resetN && cpuRead && !cpuWrite && !cpuReady) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (resetN && memWrite) mem[memAddress] = memDataOut;
    end

    always_comb begin
        blk = {memAddress[14:2], 2'b00};
        if (stall_cnt >= MISS_WAIT + 1)
            memDataIn = {mem[blk + 15'd3], mem[blk + 15'd2], mem[blk + 15'd1], mem[blk]};
        else
            memDataIn = 'x;
    end

    // ---------------- driver tasks ----------------
    // Callers enter these tasks 1 time unit after a rising edge.
    task automatic do_load(input logic [14:0] addr, output bit done, output int lat,
                           output logic [31:0] data);
        cpuRead    = 1'b1;
        cpuWrite   = 1'b0;
        cpuAddress = addr;
        done = 1'b0;
        lat  = -1;
        data = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (cpuReady) begin
                done = 1'b1;
                lat  = k;
                data = cpuDataOut;
            end
            @(posedge clock);
            #1;
        end
        cpuRead = 1'b0;
    endtask

    task automatic do_store(input logic [14:0] addr, input logic [31:0] data,
                            output bit rdy, output bit mw, output logic [14:0] ma,
                            output logic [31:0] md, output bit mw_after);
        cpuWrite   = 1'b1;
        cpuRead    = 1'b0;
        cpuAddress = addr;
        cpuDataIn  = data;
        @(negedge clock);
        rdy = cpuReady;
        mw  = memWrite;
        ma  = memAddress;
        md  = memDataOut;
        @(posedge clock);
        #1;
        cpuWrite = 1'b0;
        @(negedge clock);
        mw_after = memWrite;
        @(posedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetN = 1'b0;
        cpuRead = 1'b0;
        cpuWrite = 1'b1;
        cpuAddress = 15'd184;
        cpuDataIn = 32'h1234;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (memWrite !== 1'b0) begin failures++; $display("FAIL reset_memWrite got=%b want=0", memWrite); end
        checks++;
        if (cpuReady !== 1'b0) begin failures++; $display("FAIL reset_cpuReady got=%b want=0", cpuReady); end
        checks++;
        if (cpuDataOut !== 32'd0) begin failures++; $display("FAIL reset_cpuDataOut got=%0h want=0", cpuDataOut); end
        checks++;
        if (readCount !== 16'd0 || readHitCount !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", readCount, readHitCount);
        end
        cpuWrite = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (cpuReady !== 1'b0) begin failures++; $display("FAIL idle_cpuReady got=%b want=0", cpuReady); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_cold_load();
        bit done; int lat; logic [31:0] d;
        do_load(15'd184, done, lat, d);
        checks++;
        if (!done || lat != 3) begin failures++; $display("FAIL cold_latency got=%0d want=3", lat); end
        checks++;
        if (d !== 32'd284) begin failures++; $display("FAIL cold_data got=%0d want=284", d); end
        checks++;
        if (readCount !== 16'd1 || readHitCount !== 16'd0) begin
            failures++; $display("FAIL cold_counts got=%0d/%0d want=1/0", readCount, readHitCount);
        end
    endtask

    task automatic test_back_to_back();
        bit done; int lat; logic [31:0] d;
        for (int i = 1; i <= 3; i++) begin
            do_load(15'(184 + i), done, lat, d);
            checks++;
            if (!done || lat != 0) begin failures++; $display("FAIL hit%0d_latency got=%0d want=0", i, lat); end
            checks++;
            if (d !== 32'(284 + i)) begin failures++; $display("FAIL hit%0d_data got=%0d want=%0d", i, d, 284 + i); end
        end
        checks++;
        if (readCount !== 16'd4 || readHitCount !== 16'd3) begin
            failures++; $display("FAIL spatial_counts got=%0d/%0d want=4/3", readCount, readHitCount);
        end
    endtask

    task automatic test_store_hit();
        bit rdy, mw, mwa, done; logic [14:0] ma; logic [31:0] md, d; int lat;
        do_store(15'd185, 32'hDEAD, rdy, mw, ma, md, mwa);
        checks++;
        if (!rdy || !mw || mwa) begin
            failures++; $display("FAIL store_hit_strobes got=rdy%b mw%b next%b want=rdy1 mw1 next0", rdy, mw, mwa);
        end
        checks++;
        if (ma !== 15'd185 || md !== 32'hDEAD) begin
            failures++; $display("FAIL store_hit_bus got=%0d:%0h want=185:dead", ma, md);
        end
        do_load(15'd185, done, lat, d);
        checks++;
        if (!done || lat != 0 || d !== 32'hDEAD) begin
            failures++; $display("FAIL store_hit_reload got=lat%0d %0h want=lat0 dead", lat, d);
        end
        checks++;
        if (readCount !== 16'd5 || readHitCount !== 16'd4) begin
            failures++; $display("FAIL store_hit_counts got=%0d/%0d want=5/4", readCount, readHitCount);
        end
    endtask

    task automatic test_store_miss();
        bit rdy, mw, mwa, done; logic [14:0] ma; logic [31:0] md, d; int lat;
        do_store(15'd200, 32'd7, rdy, mw, ma, md, mwa);
        checks++;
        if (!rdy || !mw || mwa || ma !== 15'd200) begin
            failures++; $display("FAIL store_miss_bus got=rdy%b mw%b next%b addr%0d want=rdy1 mw1 next0 addr200", rdy, mw, mwa, ma);
        end
        checks++;
        if (readCount !== 16'd5) begin failures++; $display("FAIL store_not_counted got=%0d want=5", readCount); end
        do_load(15'd200, done, lat, d);
        checks++;
        if (!done || lat != 3) begin failures++; $display("FAIL store_miss_no_alloc got=lat%0d want=lat3", lat); end
        checks++;
        if (d !== 32'd7) begin failures++; $display("FAIL store_miss_data got=%0d want=7", d); end
    endtask

    task automatic test_conflict();
        bit done; int lat; logic [31:0] d;
        do_load(15'd184, done, lat, d);
        checks++;
        if (!done || lat != 0 || d !== 32'd284) begin
            failures++; $display("FAIL conflict_first got=lat%0d %0d want=lat0 284", lat, d);
        end
        do_load(15'd1208, done, lat, d);
        checks++;
        if (!done || lat != 3 || d !== 32'd0) begin
            failures++; $display("FAIL conflict_evict got=lat%0d %0d want=lat3 0", lat, d);
        end
        do_load(15'd184, done, lat, d);
        checks++;
        if (!done || lat != 3 || d !== 32'd284) begin
            failures++; $display("FAIL conflict_reload got=lat%0d %0d want=lat3 284", lat, d);
        end
        checks++;
        if (readCount !== 16'd9 || readHitCount !== 16'd5) begin
            failures++; $display("FAIL conflict_counts got=%0d/%0d want=9/5", readCount, readHitCount);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit done; int lat; logic [31:0] d;
        cpuRead    = 1'b1;
        cpuAddress = 15'd1208;
        @(posedge clock);
        #1;
        resetN  = 1'b0;
        cpuRead = 1'b0;
        @(negedge clock);
        checks++;
        if (cpuReady !== 1'b0 || readCount !== 16'd0 || readHitCount !== 16'd0) begin
            failures++; $display("FAIL mid_fill_reset got=rdy%b %0d/%0d want=rdy0 0/0", cpuReady, readCount, readHitCount);
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;
        do_load(15'd1208, done, lat, d);
        checks++;
        if (!done || lat != 3 || d !== 32'd0) begin
            failures++; $display("FAIL after_reset_miss got=lat%0d %0d want=lat3 0", lat, d);
        end
        checks++;
        if (readCount !== 16'd1 || readHitCount !== 16'd0) begin
            failures++; $display("FAIL after_reset_counts got=%0d/%0d want=1/0", readCount, readHitCount);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cold_load();
        test_back_to_back();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
